stk_al_ctrl: RTL and testbench

Free-list allocator and controller for the stack entry pool. It serves the AD stage allocation interface: empty, busy and alloc signals, plus the pointer being allocated. It also accepts pointer returns from up to ENGS_N engines, one per cycle, through round-robin arbitration. After reset it runs a self-initialisation sweep that seeds the free list with every pointer. It holds the pointer count and reports error conditions.

---
 rtl/stk_pkg.sv | 13 +
 rtl/stk_al_ctrl_fl.sv | 42 ++++
 rtl/stk_al_ctrl.sv | 119 +++++++++++
 tb/tb_stk_al_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/stk_pkg.sv
// Shared types and sizing for the stack entry pool.
package stk_pkg;
    localparam int STK_PTRS_N = 256;
    localparam int STK_ENGS_N = 4;
    localparam int STK_PTR_W  = $clog2(STK_PTRS_N);

    typedef logic [STK_PTR_W-1:0] ptr_t;

    typedef enum logic {
        AL_INIT,
        AL_RUN
    } al_state_t;
endpackage

// File: rtl/stk_al_ctrl_fl.sv
// Free-list circular FIFO: combinational head read, clocked tail write,
// registered count and empty flag.
module stk_al_ctrl_fl #(
    parameter int PTRS_N = 256,
    parameter int PTR_W  = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_push,
    input  logic [PTR_W-1:0] i_push_ptr,
    input  logic             i_pop,
    output logic [PTR_W-1:0] o_head,
    output logic [PTR_W:0]   o_cnt_r,
    output logic             o_empty_r
);
    logic [PTR_W-1:0] r_mem [PTRS_N];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [PTR_W:0]   w_cnt_nxt;

    assign o_head    = r_mem[r_head];
    assign w_cnt_nxt = o_cnt_r + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);

    // A push while full only happens alongside a pop, so the tail slot being
    // overwritten is the head entry that is leaving this same cycle.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_tail] <= i_push_ptr;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            o_cnt_r   <= '0;
            o_empty_r <= 1'b1;
        end else begin
            if (i_pop)  r_head <= r_head + PTR_W'(1);
            if (i_push) r_tail <= r_tail + PTR_W'(1);
            o_cnt_r   <= w_cnt_nxt;
            o_empty_r <= (w_cnt_nxt == '0);
        end
    end
endmodule

// File: rtl/stk_al_ctrl.sv
// Stack pointer allocator: self-seeding free list, AD-stage alloc port and
// round-robin pointer returns. Optional macro STK_AL_DOUBLE_FREE_CHK_EN.
module stk_al_ctrl import stk_pkg::*; #(
    parameter int  PTRS_N = STK_PTRS_N,
    parameter int  ENGS_N = STK_ENGS_N,
    localparam int PTR_W  = $clog2(PTRS_N)
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    i_al_alloc,
    output logic [PTR_W-1:0]        o_al_ptr,
    output logic                    o_al_empty_r,
    output logic                    o_al_busy,
    input  logic [ENGS_N-1:0]       i_free_vld,
    input  logic [ENGS_N*PTR_W-1:0] i_free_ptr,
    output logic [ENGS_N-1:0]       o_free_ack,
    output logic [PTR_W:0]          o_cnt_r,
    output logic                    o_err_r
);
    localparam int EIDX_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

    al_state_t         r_state, w_state_nxt;
    logic [PTR_W-1:0]  r_init_cnt;
    logic [EIDX_W-1:0] r_last, w_idx, w_gnt_idx;
    logic [ENGS_N-1:0] w_gnt;
    logic              w_gnt_any, w_run, w_alloc, w_fack, w_ovf, w_dbl;
    logic              w_push_run, w_push, w_err, r_err;
    logic [PTR_W-1:0]  w_free_ptr, w_push_ptr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= AL_INIT;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_al_busy   = 1'b1;
        case (r_state)
            AL_INIT: if (r_init_cnt == PTR_W'(PTRS_N-1)) w_state_nxt = AL_RUN;
            AL_RUN:  o_al_busy = 1'b0;
        endcase
    end

    // Round-robin: search starts one past the last accepted engine.
    always_comb begin
        w_gnt      = '0;
        w_gnt_idx  = '0;
        w_gnt_any  = 1'b0;
        w_idx      = '0;
        w_free_ptr = '0;
        for (int i = 0; i < ENGS_N; i++) begin
            w_idx = EIDX_W'((int'(r_last) + 1 + i) % ENGS_N);
            if (!w_gnt_any && i_free_vld[w_idx]) begin
                w_gnt_any    = 1'b1;
                w_gnt[w_idx] = 1'b1;
                w_gnt_idx    = w_idx;
            end
        end
        for (int j = 0; j < ENGS_N; j++) begin
            if (w_gnt[j]) w_free_ptr = i_free_ptr[j*PTR_W +: PTR_W];
        end
    end

    assign w_run      = (r_state == AL_RUN);
    assign w_alloc    = i_al_alloc & ~o_al_empty_r & w_run;
    assign w_fack     = w_gnt_any & w_run;
    assign o_free_ack = w_run ? w_gnt : '0;
    assign w_ovf      = w_fack & (o_cnt_r == (PTR_W+1)'(PTRS_N)) & ~w_alloc;
    assign w_push_run = w_fack & ~w_ovf & ~w_dbl;
    assign w_push     = w_run ? w_push_run : 1'b1;
    assign w_push_ptr = w_run ? w_free_ptr : r_init_cnt;
    assign w_err      = (i_al_alloc & ~w_alloc) | w_ovf | w_dbl;
    assign o_err_r    = r_err;

`ifdef STK_AL_DOUBLE_FREE_CHK_EN
    logic [PTRS_N-1:0] r_bmap;

    assign w_dbl = w_fack & ~r_bmap[w_free_ptr];

    // Free is applied before alloc, so a same-cycle free of the head pointer
    // is already flagged by w_dbl and the alloc then marks it owned.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_bmap <= '0;
        end else begin
            if (w_push_run) r_bmap[w_free_ptr] <= 1'b0;
            if (w_alloc)    r_bmap[o_al_ptr]   <= 1'b1;
        end
    end
`else
    assign w_dbl = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_init_cnt <= '0;
            r_last     <= EIDX_W'(ENGS_N-1);
            r_err      <= 1'b0;
        end else begin
            if (!w_run) r_init_cnt <= r_init_cnt + PTR_W'(1);
            if (w_fack) r_last <= w_gnt_idx;
            r_err <= r_err | w_err;
        end
    end

    stk_al_ctrl_fl #(
        .PTRS_N (PTRS_N),
        .PTR_W  (PTR_W)
    ) u_fl (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_push     (w_push),
        .i_push_ptr (w_push_ptr),
        .i_pop      (w_alloc),
        .o_head     (o_al_ptr),
        .o_cnt_r    (o_cnt_r),
        .o_empty_r  (o_al_empty_r)
    );
endmodule

// File: tb/tb_stk_al_ctrl.sv
// Scoreboard bench for stk_al_ctrl with PTRS_N=8, four engines.
module tb_stk_al_ctrl;
    localparam int PTRS_N = 8;
    localparam int ENGS_N = 4;
    localparam int PTR_W  = 3;

    logic                    clk = 1'b0;
    logic                    arst_n = 1'b0;
    logic                    al_alloc = 1'b0;
    logic [ENGS_N-1:0]       free_vld = '0;
    logic [ENGS_N*PTR_W-1:0] free_ptr = '0;
    logic [PTR_W-1:0]        al_ptr;
    logic                    al_empty, al_busy, err;
    logic [ENGS_N-1:0]       free_ack;
    logic [PTR_W:0]          cnt;

    int checks = 0;
    int errors = 0;
    logic [PTR_W-1:0]  exp_al_q [$];
    logic [ENGS_N-1:0] exp_ack_q [$];
    logic [PTR_W-1:0]  ea;
    logic [ENGS_N-1:0] ek;

    stk_al_ctrl #(.PTRS_N(PTRS_N), .ENGS_N(ENGS_N)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .i_al_alloc   (al_alloc),
        .o_al_ptr     (al_ptr),
        .o_al_empty_r (al_empty),
        .o_al_busy    (al_busy),
        .i_free_vld   (free_vld),
        .i_free_ptr   (free_ptr),
        .o_free_ack   (free_ack),
        .o_cnt_r      (cnt),
        .o_err_r      (err)
    );

    always #5 clk = ~clk;

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        if (arst_n && al_alloc && !al_busy && !al_empty) begin
            checks++;
            if (exp_al_q.size() == 0) begin
                errors++;
                $display("FAIL alloc_ptr: unexpected alloc got %0d", al_ptr);
            end else begin
                ea = exp_al_q.pop_front();
                if (al_ptr !== ea) begin
                    errors++;
                    $display("FAIL alloc_ptr: got %0d expected %0d", al_ptr, ea);
                end
            end
        end
        if (arst_n && free_ack !== '0) begin
            checks++;
            if (exp_ack_q.size() == 0) begin
                errors++;
                $display("FAIL free_ack: unexpected ack got %b", free_ack);
            end else begin
                ek = exp_ack_q.pop_front();
                if (free_ack !== ek) begin
                    errors++;
                    $display("FAIL free_ack: got %b expected %b", free_ack, ek);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc1(input logic [PTR_W-1:0] e);
        al_alloc = 1'b1;
        exp_al_q.push_back(e);
        tick();
        al_alloc = 1'b0;
    endtask

    task automatic free1(input int eng, input logic [PTR_W-1:0] p, input logic [ENGS_N-1:0] eack);
        free_vld[eng] = 1'b1;
        free_ptr[eng*PTR_W +: PTR_W] = p;
        exp_ack_q.push_back(eack);
        tick();
        free_vld = '0;
    endtask

    task automatic init_seq(input string tag);
        for (int i = 0; i < PTRS_N; i++) begin
            @(negedge clk);
            chk({tag, "_busy_init"}, 32'(al_busy), 1);
        end
        @(negedge clk);
        chk({tag, "_busy_run"}, 32'(al_busy), 0);
        chk({tag, "_empty_run"}, 32'(al_empty), 0);
        chk({tag, "_cnt_run"}, 32'(cnt), 8);
        chk({tag, "_err_run"}, 32'(err), 0);
        tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(al_busy), 1);
        chk({tag, "_empty"}, 32'(al_empty), 1);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_ack"}, 32'(free_ack), 0);
        chk({tag, "_cnt"}, 32'(cnt), 0);
    endtask

    initial begin
        repeat (2) tick();
        chk_reset("rst");
        arst_n = 1'b1;
        init_seq("init1");

        alloc1(0); alloc1(1); alloc1(2);
        chk("cnt_after3", 32'(cnt), 5);

        for (int i = 3; i < PTRS_N; i++) alloc1(PTR_W'(i));
        chk("drain_cnt", 32'(cnt), 0);
        chk("drain_empty", 32'(al_empty), 1);
        chk("drain_err", 32'(err), 0);
        al_alloc = 1'b1;
        tick();
        al_alloc = 1'b0;
        chk("empty_alloc_err", 32'(err), 1);
        chk("empty_alloc_cnt", 32'(cnt), 0);
        chk("empty_alloc_empty", 32'(al_empty), 1);

        free1(3, 6, 4'b1000);
        chk("one_cnt", 32'(cnt), 1);
        chk("one_empty", 32'(al_empty), 0);
        al_alloc = 1'b1;
        exp_al_q.push_back(6);
        free_vld[3] = 1'b1;
        free_ptr[3*PTR_W +: PTR_W] = 5;
        exp_ack_q.push_back(4'b1000);
        tick();
        al_alloc = 1'b0;
        free_vld = '0;
        chk("simul_cnt", 32'(cnt), 1);
        chk("simul_empty", 32'(al_empty), 0);
        alloc1(5);
        chk("simul_next_cnt", 32'(cnt), 0);

        // Engines 0 and 2 contend; each returns a new pointer after its ack.
        free_vld = 4'b0101;
        free_ptr[0 +: PTR_W] = 0; free_ptr[2*PTR_W +: PTR_W] = 1;
        exp_ack_q.push_back(4'b0001); tick();
        free_ptr[0 +: PTR_W] = 3;
        exp_ack_q.push_back(4'b0100); tick();
        free_ptr[2*PTR_W +: PTR_W] = 4;
        exp_ack_q.push_back(4'b0001); tick();
        free_vld = 4'b0100;
        exp_ack_q.push_back(4'b0100); tick();
        free_vld = '0;
        chk("rr_cnt", 32'(cnt), 4);
        alloc1(0); alloc1(1); alloc1(3); alloc1(4);
        chk("rr_drain_cnt", 32'(cnt), 0);

        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        repeat (4) tick();
        arst_n = 1'b0;
        #1;
        chk_reset("midinit");
        tick();
        arst_n = 1'b1;
        init_seq("init2");
        alloc1(0);
        chk("post_rst_cnt", 32'(cnt), 7);

        free1(0, 3, 4'b0001);
`ifdef STK_AL_DOUBLE_FREE_CHK_EN
        chk("unalloc_free_cnt", 32'(cnt), 7);
        chk("unalloc_free_err", 32'(err), 1);
`else
        chk("plain_free_cnt", 32'(cnt), 8);
        chk("plain_free_err", 32'(err), 0);
`endif
        free1(0, 0, 4'b0001);
        chk("final_cnt", 32'(cnt), 8);
        chk("final_err", 32'(err), 1);

        tick();
        chk("al_q_left", 32'(exp_al_q.size()), 0);
        chk("ack_q_left", 32'(exp_ack_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
